// File: rtl/level_outcome_detector.sv
// level_outcome_detector
// Watches door occupancy, hazards and the keyboard each frame and decides when
// a level is won or lost. Drives gameover/gamewin/confirm into the game-flow
// controller and re-arms on its one-cycle revive pulse.
//
// Build option: define LEVEL_OUTCOME_DEATH_DELAY_EN to insert a DYING state
// (death animation lasting DEATH_DELAY_FRAMES frames) between a hazard hit and
// gameover. Without it a hazard goes straight to LOST and dying is tied low.
module level_outcome_detector #(
    parameter int         DOOR_HOLD_FRAMES   = 30,
    parameter int         DEATH_DELAY_FRAMES = 60,
    parameter logic [7:0] CONFIRM_KEY        = 8'h28
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       revive,
    input  logic       fb_in_door,
    input  logic       ig_in_door,
    input  logic       fb_hazard,
    input  logic       ig_hazard,
    input  logic [7:0] keycode,
    output logic       gameover,
    output logic       gamewin,
    output logic       confirm,
    output logic       dying
);

    localparam int MAX_FRAMES = (DOOR_HOLD_FRAMES > DEATH_DELAY_FRAMES) ?
                                DOOR_HOLD_FRAMES : DEATH_DELAY_FRAMES;
    localparam int CW = $clog2(MAX_FRAMES + 1);

    localparam logic [CW-1:0] HOLD_LAST = CW'(DOOR_HOLD_FRAMES - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
    localparam logic [CW-1:0] DEATH_LAST = CW'(DEATH_DELAY_FRAMES - 1);
`endif

    typedef enum logic [2:0] {
        ST_DISARMED,
        ST_PLAY,
        ST_DOOR_HOLD,
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
        ST_DYING,
`endif
        ST_LOST,
        ST_WON
    } state_t;

    state_t        state;
    logic [CW-1:0] frame_cnt;
    logic [CW-1:0] frame_cnt_inc;
    logic          hazard;
    logic          both_in_door;
    logic          key_hit;
    logic          key_hit_q;

    assign hazard       = fb_hazard | ig_hazard;
    assign both_in_door = fb_in_door & ig_in_door;
    assign key_hit      = (keycode == CONFIRM_KEY);

    // The counter holds at all-ones rather than wrapping back to zero.
    assign frame_cnt_inc = (frame_cnt == CNT_MAX) ? frame_cnt : frame_cnt + 1'b1;

    // Level FSM: revive beats everything, hazards beat door logic.
    // NOTE: state and counter use <= so every branch sees the pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_DISARMED;
            frame_cnt <= '0;
        end else if (revive) begin
            state     <= ST_PLAY;
            frame_cnt <= '0;
        end else begin
            case (state)
                ST_DISARMED: state <= ST_DISARMED;
                ST_PLAY: begin
                    if (hazard) begin
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
                        state <= ST_DYING;
`else
                        state <= ST_LOST;
`endif
                        frame_cnt <= '0;
                    end else if (both_in_door) begin
                        state     <= ST_DOOR_HOLD;
                        frame_cnt <= '0;
                    end
                end
                ST_DOOR_HOLD: begin
                    if (hazard) begin
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
                        state <= ST_DYING;
`else
                        state <= ST_LOST;
`endif
                        frame_cnt <= '0;
                    end else if (!both_in_door) begin
                        state <= ST_PLAY;
                    end else if (frame_tick) begin
                        if (frame_cnt == HOLD_LAST) begin
                            state <= ST_WON;
                        end
                        frame_cnt <= frame_cnt_inc;
                    end
                end
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
                ST_DYING: begin
                    if (frame_tick) begin
                        if (frame_cnt == DEATH_LAST) begin
                            state <= ST_LOST;
                        end
                        frame_cnt <= frame_cnt_inc;
                    end
                end
`endif
                ST_LOST: state <= ST_LOST;
                ST_WON:  state <= ST_WON;
                default: state <= ST_DISARMED;
            endcase
        end
    end

    // Key history so a held key produces one confirm and a key held through
    // reset or into LOST/WON cannot fire until it is released.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            key_hit_q <= 1'b0;
        end else begin
            key_hit_q <= key_hit;
        end
    end

    // Outputs decode the current state register, never the next state.
    assign gameover = (state == ST_LOST);
    assign gamewin  = (state == ST_WON);
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
    assign dying    = (state == ST_DYING);
`else
    assign dying    = 1'b0;
`endif
    assign confirm  = key_hit & ~key_hit_q & ((state == ST_LOST) | (state == ST_WON));

endmodule

// File: tb/tb_level_outcome_detector.sv
// Self-checking bench for level_outcome_detector (DOOR_HOLD_FRAMES=3,
// DEATH_DELAY_FRAMES=2, frame_tick every 4 clocks). Expected output vectors
// {gameover, gamewin, dying, confirm} are queued when stimulus is applied and
// popped when the outputs are sampled. Expectations follow whichever build of
// LEVEL_OUTCOME_DEATH_DELAY_EN the design is compiled with.
module tb_level_outcome_detector;

    localparam int         HOLD  = 3;
    localparam int         DEATH = 2;
    localparam logic [7:0] ENTER = 8'h28;

    // Output vector right after a hazard hit in PLAY/DOOR_HOLD.
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
    localparam logic [3:0] HIT = 4'b0010;
`else
    localparam logic [3:0] HIT = 4'b1000;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       revive;
    logic       fb_in_door;
    logic       ig_in_door;
    logic       fb_hazard;
    logic       ig_hazard;
    logic [7:0] keycode;
    logic       gameover;
    logic       gamewin;
    logic       confirm;
    logic       dying;

    logic [3:0] sb[$];
    logic [3:0] exp_v;
    int         passed = 0;
    int         total  = 0;

    always #5 Clk = ~Clk;

    level_outcome_detector #(
        .DOOR_HOLD_FRAMES  (HOLD),
        .DEATH_DELAY_FRAMES(DEATH),
        .CONFIRM_KEY       (ENTER)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_tick(frame_tick),
        .revive    (revive),
        .fb_in_door(fb_in_door),
        .ig_in_door(ig_in_door),
        .fb_hazard (fb_hazard),
        .ig_hazard (ig_hazard),
        .keycode   (keycode),
        .gameover  (gameover),
        .gamewin   (gamewin),
        .confirm   (confirm),
        .dying     (dying)
    );

    function automatic logic [3:0] obs();
        return {gameover, gamewin, dying, confirm};
    endfunction

    // One clock with the current inputs; returns 1 ns after the edge.
    task automatic step(input logic ft);
        frame_tick = ft;
        @(posedge Clk);
        #1;
        frame_tick = 1'b0;
    endtask

    // n frames, each 3 idle clocks followed by a tick clock.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0);
            step(1'b0);
            step(1'b0);
            step(1'b1);
        end
    endtask

    task automatic idle_inputs();
        fb_in_door = 1'b0;
        ig_in_door = 1'b0;
        fb_hazard  = 1'b0;
        ig_hazard  = 1'b0;
        keycode    = 8'h00;
    endtask

    task automatic do_revive();
        revive = 1'b1;
        step(1'b0);
        revive = 1'b0;
    endtask

    task automatic test_reset();
        Reset      = 1'b1;
        revive     = 1'b0;
        frame_tick = 1'b0;
        idle_inputs();
        fb_in_door = 1'b1;
        ig_in_door = 1'b1;
        keycode    = ENTER;
        sb.push_back(4'b0000);
        step(1'b0);
        step(1'b0);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL reset_values: got %b expected %b", obs(), exp_v);
        else passed++;
        Reset = 1'b0;
        // DISARMED ignores doors, Enter and (later) hazards without a revive.
        for (int i = 0; i < 100; i++) begin
            fb_hazard = (i >= 50);
            sb.push_back(4'b0000);
            step(i % 4 == 3);
            exp_v = sb.pop_front();
            total++;
            if (obs() !== exp_v) $display("FAIL disarmed_idle cycle %0d: got %b expected %b", i, obs(), exp_v);
            else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_win();
        idle_inputs();
        do_revive();
        fb_in_door = 1'b1;
        ig_in_door = 1'b1;
        step(1'b0);
        for (int t = 1; t <= HOLD; t++) begin
            sb.push_back((t == HOLD) ? 4'b0100 : 4'b0000);
            run_ticks(1);
            exp_v = sb.pop_front();
            total++;
            if (obs() !== exp_v) $display("FAIL win_tick%0d: got %b expected %b", t, obs(), exp_v);
            else passed++;
        end
        // WON is terminal.
        fb_in_door = 1'b0;
        sb.push_back(4'b0100);
        run_ticks(2);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL win_terminal: got %b expected %b", obs(), exp_v);
        else passed++;
        // revive drops gamewin in the next cycle.
        sb.push_back(4'b0000);
        do_revive();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL win_revive_drop: got %b expected %b", obs(), exp_v);
        else passed++;
        // Door pair broken after 2 ticks returns to PLAY.
        fb_in_door = 1'b1;
        ig_in_door = 1'b1;
        step(1'b0);
        run_ticks(2);
        ig_in_door = 1'b0;
        step(1'b0);
        sb.push_back(4'b0000);
        run_ticks(2);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL door_broken: got %b expected %b", obs(), exp_v);
        else passed++;
        // Re-entering DOOR_HOLD starts a fresh count of HOLD ticks.
        ig_in_door = 1'b1;
        step(1'b0);
        sb.push_back(4'b0000);
        run_ticks(HOLD - 1);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL door_recount_early: got %b expected %b", obs(), exp_v);
        else passed++;
        sb.push_back(4'b0100);
        run_ticks(1);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL door_recount_win: got %b expected %b", obs(), exp_v);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_hazard();
        idle_inputs();
        do_revive();
        // Doors and hazard in the same cycle: hazard wins.
        fb_in_door = 1'b1;
        ig_in_door = 1'b1;
        fb_hazard  = 1'b1;
        sb.push_back(HIT);
        step(1'b0);
        fb_hazard = 1'b0;
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL hazard_first_cycle: got %b expected %b", obs(), exp_v);
        else passed++;
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
        sb.push_back(4'b0010);
        run_ticks(DEATH - 1);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL dying_before_last_tick: got %b expected %b", obs(), exp_v);
        else passed++;
        sb.push_back(4'b1000);
        run_ticks(1);
`else
        sb.push_back(4'b1000);
        run_ticks(DEATH);
`endif
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL hazard_gameover: got %b expected %b", obs(), exp_v);
        else passed++;
        // Hazard on the very tick that would complete the door hold.
        do_revive();
        step(1'b0);
        run_ticks(HOLD - 1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        ig_hazard = 1'b1;
        sb.push_back(HIT);
        step(1'b1);
        ig_hazard = 1'b0;
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL hazard_beats_win: got %b expected %b", obs(), exp_v);
        else passed++;
        sb.push_back(4'b1000);
        run_ticks(DEATH);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL lost_never_wins: got %b expected %b", obs(), exp_v);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_confirm();
        int pulses;
        // Currently LOST. Press and hold Enter for 10 clocks.
        idle_inputs();
        step(1'b0);
        keycode = ENTER;
        #1;
        sb.push_back(4'b1001);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL confirm_press: got %b expected %b", obs(), exp_v);
        else passed++;
        pulses = int'(confirm);
        for (int i = 0; i < 10; i++) begin
            step(1'b0);
            pulses += int'(confirm);
        end
        total++;
        if (pulses !== 1) $display("FAIL confirm_held_pulses: got %0d expected 1", pulses);
        else passed++;
        // Release and press again.
        keycode = 8'h00;
        step(1'b0);
        keycode = ENTER;
        #1;
        sb.push_back(4'b1001);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL confirm_repress: got %b expected %b", obs(), exp_v);
        else passed++;
        step(1'b0);
        // Enter in PLAY must not confirm.
        keycode = 8'h00;
        do_revive();
        keycode = ENTER;
        #1;
        sb.push_back(4'b0000);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL confirm_in_play: got %b expected %b", obs(), exp_v);
        else passed++;
        step(1'b0);
        // Enter held while entering LOST does not pulse.
        ig_hazard = 1'b1;
        step(1'b0);
        ig_hazard = 1'b0;
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
        run_ticks(DEATH);
`endif
        sb.push_back(4'b1000);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL confirm_held_into_lost: got %b expected %b", obs(), exp_v);
        else passed++;
        keycode = 8'h00;
        step(1'b0);
        keycode = ENTER;
        #1;
        sb.push_back(4'b1001);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL confirm_after_release: got %b expected %b", obs(), exp_v);
        else passed++;
        step(1'b0);
        idle_inputs();
        step(1'b0);
    endtask

    task automatic test_revive_mid();
        idle_inputs();
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
        do_revive();
        fb_hazard = 1'b1;
        step(1'b0);
        fb_hazard = 1'b0;
        run_ticks(1);
        sb.push_back(4'b0000);
        do_revive();
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL revive_mid_dying: got %b expected %b", obs(), exp_v);
        else passed++;
        fb_hazard = 1'b1;
        step(1'b0);
        fb_hazard = 1'b0;
        sb.push_back(4'b0010);
        run_ticks(DEATH - 1);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL fresh_death_early: got %b expected %b", obs(), exp_v);
        else passed++;
        sb.push_back(4'b1000);
        run_ticks(1);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL fresh_death_gameover: got %b expected %b", obs(), exp_v);
        else passed++;
`endif
        // From LOST: revive together with a hazard goes to PLAY first.
        revive    = 1'b1;
        fb_hazard = 1'b1;
        sb.push_back(4'b0000);
        step(1'b0);
        revive = 1'b0;
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL revive_with_hazard: got %b expected %b", obs(), exp_v);
        else passed++;
        sb.push_back(HIT);
        step(1'b0);
        fb_hazard = 1'b0;
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL hazard_reevaluated: got %b expected %b", obs(), exp_v);
        else passed++;
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        do_revive();
        fb_hazard = 1'b1;
        step(1'b0);
        fb_hazard = 1'b0;
`ifdef LEVEL_OUTCOME_DEATH_DELAY_EN
        run_ticks(1);
`endif
        Reset = 1'b1;
        sb.push_back(4'b0000);
        step(1'b0);
        Reset = 1'b0;
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL reset_mid_level: got %b expected %b", obs(), exp_v);
        else passed++;
        // Back in DISARMED: hazards and ticks never yield gameover.
        fb_hazard = 1'b1;
        sb.push_back(4'b0000);
        run_ticks(DEATH + 1);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) $display("FAIL no_gameover_after_reset: got %b expected %b", obs(), exp_v);
        else passed++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_win();
        test_hazard();
        test_confirm();
        test_revive_mid();
        test_reset_mid();
        total++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/level_outcome_detector.md
# level_outcome_detector

Upstream neighbour of the game-flow controller. Each frame it watches per-player door-occupancy and hazard flags from the collision logic and the current keyboard keycode. It decides when a level is lost or won and drives the `gameover`, `gamewin` and `confirm` inputs of the game-flow controller. It re-arms on that controller's one-cycle `revive` pulse.

## Interface

Parameters:
- `DOOR_HOLD_FRAMES`, default 30: consecutive frames both players must stand in their doors before a win; legal range ≥1.
- `DEATH_DELAY_FRAMES`, default 60: frames of death animation between a hazard hit and `gameover`; legal range ≥1.
- `CONFIRM_KEY`, default 8'h28: keycode (Enter) that produces `confirm`.

Ports (one clock; reset is synchronous and active-high):
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high reset.
- `frame_tick` in 1: one-`Clk` pulse per video frame; all frame counting advances only on this pulse.
- `revive` in 1: one-cycle pulse; starts or restarts a level.
- `fb_in_door` in 1: fireboy overlaps the fire door.
- `ig_in_door` in 1: icegirl overlaps the ice door.
- `fb_hazard` in 1: fireboy touches water, goo or an enemy.
- `ig_hazard` in 1: icegirl touches lava, goo or an enemy.
- `keycode` in 8: current keyboard keycode; 8'h00 means no key.
- `gameover` out 1: level lost; a level signal.
- `gamewin` out 1: level won; a level signal.
- `confirm` out 1: one-cycle pulse on a press of `CONFIRM_KEY`.
- `dying` out 1: death animation in progress; drives sprite selection.

## Operation

The block has one FSM with these states: DISARMED, PLAY, DOOR_HOLD, DYING, LOST, WON.

Common rules:
- `Reset` forces DISARMED, clears `frame_cnt`, and clears the key history register.
- `revive` in any state forces PLAY and clears `frame_cnt`. `revive` has priority over every other transition.
- `frame_cnt` width is `$clog2(max(DOOR_HOLD_FRAMES, DEATH_DELAY_FRAMES)+1)`. It saturates and never wraps.
- A hazard on either player has priority over door logic in the same cycle.

State transitions:
- **DISARMED**: ignores all player inputs. Leaves only on `revive`.
- **PLAY**:
  - `fb_hazard|ig_hazard` → DYING, `frame_cnt`=0.
  - Otherwise `fb_in_door&ig_in_door` → DOOR_HOLD, `frame_cnt`=0.
- **DOOR_HOLD**:
  - Hazard → DYING.
  - Either door flag low → PLAY.
  - On `frame_tick`, `frame_cnt`++. If `frame_cnt` == `DOOR_HOLD_FRAMES-1` when the tick arrives → WON.
- **DYING**:
  - On `frame_tick`, `frame_cnt`++. If `frame_cnt` == `DEATH_DELAY_FRAMES-1` when the tick arrives → LOST.
  - Further hazard and door inputs are ignored.
- **LOST / WON**: terminal. Leave only on `revive` or `Reset`.

Outputs are decoded from the state register, not from the next state:
- `gameover` = (state==LOST).
- `gamewin` = (state==WON).
- `dying` = (state==DYING).

Confirm generation:
- `key_hit` = (`keycode`==`CONFIRM_KEY`), registered once as `key_hit_q`.
- `confirm` = `key_hit & ~key_hit_q & (state==LOST | state==WON)`. This is a combinational pulse from the current state plus the registered history.
- Holding the key yields exactly one pulse.
- A key held down while entering LOST/WON does not pulse until it is released and pressed again.

## Timing

- Reset values: `gameover`=0, `gamewin`=0, `dying`=0, `confirm`=0. The key history register is cleared; an Enter key held through reset does not produce a pulse.
- Hazard sampled high in PLAY at edge N → `dying`=1 from cycle N+1.
- Win latency: the door pair is first seen at edge N. `gamewin` rises in the cycle after the `DOOR_HOLD_FRAMES`-th subsequent `frame_tick`.
- Loss latency: `gameover` rises in the cycle after the `DEATH_DELAY_FRAMES`-th `frame_tick` after entering DYING.
- `revive` at edge N drops `gameover`/`gamewin` at cycle N+1. This is the same cycle the controller leaves its revive state.
- `frame_tick` coincident with the transition into DOOR_HOLD/DYING is not counted.
- `revive` coincident with a hazard → PLAY; the hazard is re-evaluated next cycle.
- `Reset` mid-DYING → DISARMED; no `gameover` is produced.

## Configuration

- `LEVEL_OUTCOME_DEATH_DELAY_EN` defined: DYING exists as described above.
- Undefined:
  - DYING is compiled out, and `DEATH_DELAY_FRAMES` is ignored.
  - A hazard in PLAY/DOOR_HOLD goes straight to LOST, so `gameover` rises at cycle N+1.
  - `dying` is tied to 0.

## Test plan

All scenarios use `DOOR_HOLD_FRAMES`=3, `DEATH_DELAY_FRAMES`=2, and `frame_tick` every 4 clocks unless noted.

1. Reset, hold both doors high with no `revive` → state stays DISARMED; `gamewin`=0 for 100 clocks.
2. `revive`, then both doors high for 3 ticks → `gamewin`=1 the cycle after the 3rd tick. `ig_in_door` dropped after 2 ticks instead → back to PLAY, `gamewin`=0.
3. `revive`, then doors high and `fb_hazard` pulse in the same cycle → `dying`=1 next cycle. `gameover`=1 the cycle after the 2nd tick; `gamewin` never rises.
4. In LOST, hold `keycode`=8'h28 for 10 clocks → exactly one `confirm` pulse. With `keycode`=8'h28 in PLAY → `confirm`=0.
5. `revive` during DYING after 1 tick → `dying`=0, PLAY. A fresh hazard needs 2 full ticks to reach `gameover`.
6. Build without `LEVEL_OUTCOME_DEATH_DELAY_EN`, then `ig_hazard` in PLAY at edge N → `gameover`=1 at N+1, `dying` constantly 0.
